// File: rtl/imem_loader.sv
// Boot-time program loader: byte stream -> 32-bit instruction memory writes.
// Releases the core only after the trailing XOR checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_n;
    logic [7:0]            r_csum;
    logic [1:0]            r_bcnt;
    logic [ADDR_WIDTH:0]   r_widx;
    logic [ADDR_WIDTH:0]   r_words;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_run;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_acc;
    logic [16:0]           w_hdr_n;
    logic                  w_last;
    logic                  w_restart;

    assign w_ready   = (r_state != S_DONE) && (r_state != S_ERR);
    assign w_acc     = in_valid && w_ready;
    assign w_hdr_n   = {1'b0, in_data, r_n[7:0]};
    // Decided on the 4th byte so a checksum byte arriving during the
    // write-strobe cycle is already treated as the checksum.
    assign w_last    = (17'(r_widx) + 17'd1) == {1'b0, r_n};
    assign w_restart = reload && !w_ready;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR_LO: if (w_acc) w_next = S_HDR_HI;
            S_HDR_HI: begin
                if (w_acc) begin
                    if (w_hdr_n > CAP)       w_next = S_ERR;
                    else if (w_hdr_n == '0)  w_next = S_CSUM;
                    else                     w_next = S_DATA;
                end
            end
            S_DATA: if (w_acc && r_bcnt == 2'd3 && w_last) w_next = S_CSUM;
            S_CSUM: begin
                if (w_acc) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
            end
            S_DONE: if (reload) w_next = S_HDR_LO;
            S_ERR:  if (reload) w_next = S_HDR_LO;
            default: w_next = S_HDR_LO;
        endcase
    end

    // State register with status flags registered alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HDR_LO;
            r_run   <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= (w_next == S_DONE);
            r_err   <= (w_next == S_ERR);
            r_busy  <= (w_next != S_DONE) && (w_next != S_ERR);
        end
    end

    // Header capture, word assembly, write strobe and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n     <= '0;
            r_csum  <= '0;
            r_bcnt  <= '0;
            r_widx  <= '0;
            r_words <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_widx  <= r_widx + 1'b1;
                r_words <= r_words + 1'b1;
            end
            if (w_restart) begin
                r_csum  <= '0;
                r_bcnt  <= '0;
                r_widx  <= '0;
                r_words <= '0;
            end
            if (w_acc) begin
                unique case (r_state)
                    S_HDR_LO: begin
                        r_n[7:0] <= in_data;
                        r_csum   <= r_csum ^ in_data;
                    end
                    S_HDR_HI: begin
                        r_n[15:8] <= in_data;
                        r_csum    <= r_csum ^ in_data;
                    end
                    S_DATA: begin
                        r_wdata[8*r_bcnt +: 8] <= in_data;
                        r_csum <= r_csum ^ in_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_we   <= 1'b1;
                            r_addr <= r_widx[ADDR_WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = w_ready;
    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign cpu_run      = r_run;
    assign busy         = r_busy;
    assign error        = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (default and 16-word memory)
// driven from one stimulus port selected by sel.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic in_valid;
    logic [7:0] in_data;
    logic reload;

    logic        rdy0, we0, run0, busy0, err0;
    logic [9:0]  addr0;
    logic [31:0] data0;
    logic [10:0] words0;

    logic        rdy4, we4, run4, busy4, err4;
    logic [3:0]  addr4;
    logic [31:0] data4;
    logic [4:0]  words4;

    logic w_rdy;
    assign w_rdy = sel ? rdy4 : rdy0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(rdy0),
        .reload(reload && !sel),
        .im_we(we0), .im_addr(addr0), .im_wdata(data0),
        .cpu_run(run0), .busy(busy0), .error(err0),
        .words_loaded(words0)
    );

    imem_loader #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_data(in_data), .in_ready(rdy4),
        .reload(reload && sel),
        .im_we(we4), .im_addr(addr4), .im_wdata(data4),
        .cpu_run(run4), .busy(busy4), .error(err4),
        .words_loaded(words4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_drop  = 0;
    int n_we4   = 0;
    logic [3:0] last_a4;
    logic [9:0]  log_a[$];
    logic [31:0] log_d[$];

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (we0) begin
            log_a.push_back(addr0);
            log_d.push_back(data0);
        end
        if (we4) begin
            n_we4++;
            last_a4 = addr4;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!w_rdy) n_drop++;
        end
    endtask

    // Entered and left just after a falling edge
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (!w_rdy && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_drop += t;
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$], input int gap);
        foreach (q[i]) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send(q[i]);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic chk_log(input int i, input logic [9:0] a,
                           input logic [31:0] d);
        logic [9:0]  ga;
        logic [31:0] gd;
        ga = (i < log_a.size()) ? log_a[i] : 10'h3ff;
        gd = (i < log_d.size()) ? log_d[i] : 32'hffffffff;
        chk($sformatf("wr%0d_addr", i), ga, a);
        chk($sformatf("wr%0d_data", i), gd, d);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_ready"}, rdy0, 1);
        chk({p, "_we"},    we0, 0);
        chk({p, "_addr"},  addr0, 0);
        chk({p, "_wdata"}, data0, 0);
        chk({p, "_run"},   run0, 0);
        chk({p, "_busy"},  busy0, 1);
        chk({p, "_err"},   err0, 0);
        chk({p, "_words"}, words0, 0);
    endtask

    logic [7:0] s2[$];
    logic [7:0] s1[$];
    logic [7:0] q[$];

    initial begin
        s2 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
        // 01^44^33^22^11 = 45
        s1 = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
        sel = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        reload = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b1;
        @(negedge clk);

        // N=2 back-to-back, checksum 0x28
        send_q(s2, 0);
        chk("n2_we_last", we0, 1);
        chk("n2_run_before", run0, 0);
        send(8'h28);
        chk("n2_nwr", log_a.size(), 2);
        chk_log(0, 10'd0, 32'h12345678);
        chk_log(1, 10'd1, 32'hDEADBEEF);
        chk("n2_words", words0, 2);
        chk("n2_run", run0, 1);
        chk("n2_busy", busy0, 0);
        chk("n2_ready", rdy0, 0);

        // Reload from DONE, then N=1
        pulse_reload();
        chk("rl_run_drop", run0, 0);
        chk("rl_busy", busy0, 1);
        chk("rl_words", words0, 0);
        log_a.delete(); log_d.delete();
        send_q(s1, 0);
        chk("n1_nwr", log_a.size(), 1);
        chk_log(0, 10'd0, 32'h11223344);
        chk("n1_run", run0, 1);

        // Bad checksum
        pulse_reload();
        send_q(s2, 0);
        send(8'hD7);
        chk("bad_err", err0, 1);
        chk("bad_run", run0, 0);
        chk("bad_ready", rdy0, 0);
        pulse_reload();
        chk("bad_rl_err", err0, 0);
        chk("bad_rl_ready", rdy0, 1);
        chk("bad_rl_busy", busy0, 1);

        // N=0
        log_a.delete(); log_d.delete();
        q = '{8'h00, 8'h00, 8'h00};
        send_q(q, 0);
        chk("n0_run", run0, 1);
        chk("n0_words", words0, 0);
        chk("n0_nwr", log_a.size(), 0);

        // N=2 with random valid gaps
        pulse_reload();
        log_a.delete(); log_d.delete();
        n_drop = 0;
        send_q(s2, 3);
        idle($urandom_range(0, 3));
        send(8'h28);
        chk("gap_drops", n_drop, 0);
        chk("gap_nwr", log_a.size(), 2);
        chk_log(0, 10'd0, 32'h12345678);
        chk_log(1, 10'd1, 32'hDEADBEEF);
        chk("gap_run", run0, 1);

        // Reset mid-DATA after 5 payload bytes
        pulse_reload();
        q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        send_q(q, 0);
        rst = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        log_a.delete(); log_d.delete();
        send_q(s1, 0);
        chk("mid_nwr", log_a.size(), 1);
        chk_log(0, 10'd0, 32'h11223344);
        chk("mid_run", run0, 1);

        // 16-word memory: N=17 overflows
        sel = 1'b1;
        q = '{8'h11, 8'h00};
        send_q(q, 0);
        chk("ovf_err", err4, 1);
        chk("ovf_ready", rdy4, 0);
        chk("ovf_busy", busy4, 0);
        idle(3);
        chk("ovf_nwe", n_we4, 0);

        // N=16 fills the memory exactly; payload xor is 0 so csum = 0x10
        pulse_reload();
        q = '{8'h10, 8'h00};
        send_q(q, 0);
        chk("full_busy", busy4, 1);
        chk("full_err", err4, 0);
        q.delete();
        for (int i = 0; i < 16; i++) begin
            q.push_back(8'(i));
            q.push_back(8'h00);
            q.push_back(8'h00);
            q.push_back(8'h00);
        end
        q.push_back(8'h10);
        send_q(q, 0);
        chk("full_nwe", n_we4, 16);
        chk("full_last_addr", last_a4, 15);
        chk("full_words", words4, 16);
        chk("full_run", run4, 1);
        chk("full_err2", err4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
